// File: rtl/buf_table_issue_pkg.sv
// rtl/buf_table_issue_pkg.sv - shared types and defaults for the buffer table issue block
// Contents: opcode encoding, scratchpad one-hot tags, descriptor layout,
//           default sizing constants, per-channel engine state encoding.
`timescale 1ns/1ps
package buf_table_issue_pkg;

  localparam int BT_NUM_CH        = 3;
  localparam int BUFF_TABLE_DEPTH = 10;
  localparam int BT_ADDR_W        = 16;
  localparam int BT_OP_W          = 5;
  localparam int BT_IMM_W         = 16;

  typedef enum logic [BT_OP_W-1:0] {
    OP_LD_MEM  = 5'd0,
    OP_ST_MEM  = 5'd1,
    OP_RD_BUF  = 5'd2,
    OP_WR_BUF  = 5'd3,
    OP_COMPUTE = 5'd4
  } opcode_e;

  typedef enum logic [2:0] {
    SP_IBUF = 3'b001,
    SP_WBUF = 3'b010,
    SP_OBUF = 3'b100
  } scratchpad_t;

  typedef struct packed {
    opcode_e                opcode;
    logic [2:0]             mem_width;
    logic [BT_IMM_W-1:0]    num_words;
    logic [BT_ADDR_W-1:0]   base;
    logic [BT_IMM_W-1:0]    stride;
  } buf_desc_t;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_LOAD  = 2'd1,
    ENG_ISSUE = 2'd2
  } eng_state_e;

endpackage

// File: rtl/buf_table_issue_chan.sv
// rtl/buf_table_issue_chan.sv - one channel: descriptor FIFO plus strided address issue engine
// Ports: i_clk/i_rst/i_flush control; i_push + descriptor fields in; o_full;
//        o_req_* / i_req_ready request port; o_occupancy FIFO count; o_busy.
`timescale 1ns/1ps
module buf_chan_engine
  import buf_table_issue_pkg::*;
#(
  parameter int DEPTH  = BUFF_TABLE_DEPTH,
  parameter int ADDR_W = BT_ADDR_W,
  parameter int IMM_W  = BT_IMM_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_push_write,
  input  logic [2:0]                   i_push_width,
  input  logic [IMM_W-1:0]             i_push_num_words,
  input  logic [ADDR_W-1:0]            i_push_base,
  input  logic [IMM_W-1:0]             i_push_stride,
  output logic                         o_full,
  output logic                         o_req_valid,
  input  logic                         i_req_ready,
  output logic [ADDR_W-1:0]            o_req_addr,
  output logic [2:0]                   o_req_width,
  output logic                         o_req_write,
  output logic                         o_req_last,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
  output logic                         o_busy
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  // Entry layout, MSB first: write, width, num_words, base, stride
  localparam int ENT_W = 1 + 3 + IMM_W + ADDR_W + IMM_W;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  eng_state_e        r_state;
  eng_state_e        w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [IMM_W-1:0]  r_k;
  logic [IMM_W-1:0]  r_nw;
  logic [IMM_W-1:0]  r_stride;
  logic [2:0]        r_width;
  logic              r_write;

  logic [ENT_W-1:0]  w_head;
  logic              w_hs;
  logic              w_pop;
  logic              w_clear;

  assign w_clear     = i_rst | i_flush;
  assign w_head      = r_mem[r_rd_ptr];
  assign o_req_valid = (r_state == ENG_ISSUE);
  assign o_req_last  = o_req_valid & (r_k == r_nw - 1'b1);
  assign o_req_addr  = r_addr;
  assign o_req_width = r_width;
  assign o_req_write = r_write;
  assign w_hs        = o_req_valid & i_req_ready;
  // The head stays in the FIFO until its final word is handshaken.
  assign w_pop       = w_hs & o_req_last;
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_occupancy = r_count;
  assign o_busy      = (r_count != '0) | (r_state != ENG_IDLE);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= {i_push_write, i_push_width, i_push_num_words, i_push_base, i_push_stride};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clear) r_state <= ENG_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ENG_IDLE:  if (r_count != '0) w_state_nxt = ENG_LOAD;
      ENG_LOAD:  w_state_nxt = ENG_ISSUE;
      ENG_ISSUE: if (w_pop) w_state_nxt = ENG_IDLE;
      default:   w_state_nxt = ENG_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_addr   <= '0;
      r_k      <= '0;
      r_nw     <= '0;
      r_stride <= '0;
      r_width  <= '0;
      r_write  <= 1'b0;
    end else if (r_state == ENG_LOAD) begin
      r_stride <= w_head[0 +: IMM_W];
      r_addr   <= w_head[IMM_W +: ADDR_W];
      r_nw     <= w_head[IMM_W+ADDR_W +: IMM_W];
      r_width  <= w_head[2*IMM_W+ADDR_W +: 3];
      r_write  <= w_head[ENT_W-1];
      r_k      <= '0;
    end else if (w_hs) begin
      // Stride is zero-extended; the sum wraps modulo 2^ADDR_W.
      r_addr <= r_addr + ADDR_W'(r_stride);
      r_k    <= r_k + 1'b1;
    end
  end

endmodule

// File: rtl/buf_table_issue.sv
// rtl/buf_table_issue.sv - multi-channel buffer table: descriptor acceptance/reject and channel fan-out
// Ports: CLK, RST (sync, active high), flush; in_* descriptor handshake with in_err;
//        per-channel req_valid/req_ready/req_addr/req_width/req_write/req_last; occupancy; busy.
`timescale 1ns/1ps
module buf_table_issue
  import buf_table_issue_pkg::*;
#(
  parameter int NUM_CH = BT_NUM_CH,
  parameter int DEPTH  = BUFF_TABLE_DEPTH,
  parameter int ADDR_W = BT_ADDR_W,
  parameter int OP_W   = BT_OP_W,
  parameter int IMM_W  = BT_IMM_W
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_CH-1:0]                    in_chan,
  input  logic [OP_W-1:0]                      in_opcode,
  input  logic [2:0]                           in_mem_width,
  input  logic [IMM_W-1:0]                     in_num_words,
  input  logic [ADDR_W-1:0]                    in_base,
  input  logic [IMM_W-1:0]                     in_stride,
  output logic                                 in_err,
  output logic [NUM_CH-1:0]                    req_valid,
  input  logic [NUM_CH-1:0]                    req_ready,
  output logic [NUM_CH*ADDR_W-1:0]             req_addr,
  output logic [NUM_CH*3-1:0]                  req_width,
  output logic [NUM_CH-1:0]                    req_write,
  output logic [NUM_CH-1:0]                    req_last,
  output logic [NUM_CH*$clog2(DEPTH+1)-1:0]    occupancy,
  output logic                                 busy
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic              w_onehot;
  logic              w_op_ok;
  logic              w_reject;
  logic              w_sel_full;
  logic              w_push_ok;
  logic              w_is_write;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_busy;
  logic              r_err;

  assign w_onehot   = (in_chan != '0) && ((in_chan & (in_chan - 1'b1)) == '0);
  assign w_op_ok    = (in_opcode == OP_W'(OP_LD_MEM)) || (in_opcode == OP_W'(OP_ST_MEM)) ||
                      (in_opcode == OP_W'(OP_RD_BUF)) || (in_opcode == OP_W'(OP_WR_BUF));
  assign w_is_write = (in_opcode == OP_W'(OP_ST_MEM)) || (in_opcode == OP_W'(OP_WR_BUF));
  assign w_reject   = in_valid & ~RST & ~flush & (~w_onehot | ~w_op_ok | (in_num_words == '0));
  assign w_sel_full = |(in_chan & w_full);
  // Malformed descriptors are swallowed (ready forced) so the decoder never stalls on them.
  assign in_ready   = ~RST & ~flush & ((w_onehot & ~w_sel_full) | w_reject);
  assign w_push_ok  = in_valid & in_ready & ~w_reject;
  assign in_err     = r_err;
  assign busy       = |w_busy;

  always_ff @(posedge CLK) begin
    if (RST) r_err <= 1'b0;
    else     r_err <= w_reject;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    buf_chan_engine #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .IMM_W  (IMM_W)
    ) u_eng (
      .i_clk            (CLK),
      .i_rst            (RST),
      .i_flush          (flush),
      .i_push           (w_push_ok & in_chan[c]),
      .i_push_write     (w_is_write),
      .i_push_width     (in_mem_width),
      .i_push_num_words (in_num_words),
      .i_push_base      (in_base),
      .i_push_stride    (in_stride),
      .o_full           (w_full[c]),
      .o_req_valid      (req_valid[c]),
      .i_req_ready      (req_ready[c]),
      .o_req_addr       (req_addr[c*ADDR_W +: ADDR_W]),
      .o_req_width      (req_width[c*3 +: 3]),
      .o_req_write      (req_write[c]),
      .o_req_last       (req_last[c]),
      .o_occupancy      (occupancy[c*CNT_W +: CNT_W]),
      .o_busy           (w_busy[c])
    );
  end

endmodule

// File: tb/tb_buf_table_issue.sv
// tb/tb_buf_table_issue.sv - self-checking bench for buf_table_issue
`timescale 1ns/1ps
module tb_buf_table_issue;
  import buf_table_issue_pkg::*;

  localparam int NCH = 3;
  localparam int D   = 10;
  localparam int AW  = 16;
  localparam int CW  = 4;
  localparam int LOGN = 256;

  logic CLK = 1'b0;
  logic RST, flush, in_valid, in_ready, in_err, busy;
  logic [2:0] in_chan, in_mem_width;
  logic [4:0] in_opcode;
  logic [15:0] in_num_words, in_base, in_stride;
  logic [NCH-1:0] req_valid, req_ready, req_write, req_last;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*3-1:0] req_width;
  logic [NCH*CW-1:0] occupancy;

  always #5 CLK = ~CLK;

  buf_table_issue dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_opcode(in_opcode), .in_mem_width(in_mem_width),
    .in_num_words(in_num_words), .in_base(in_base), .in_stride(in_stride), .in_err(in_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_width(req_width),
    .req_write(req_write), .req_last(req_last), .occupancy(occupancy), .busy(busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per channel, a list of queued descriptors, the word index of the head,
  // and how many edges the head has been at the front (requests start at 2).
  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    int          nw;
    logic        wr;
    logic [2:0]  w;
  } d_t;

  d_t   mq [NCH][D+2];
  int   mcnt [NCH] = '{0, 0, 0};
  int   mk   [NCH] = '{0, 0, 0};
  int   mage [NCH] = '{0, 0, 0};
  logic exp_err = 1'b0;

  logic [15:0] log_addr [NCH][LOGN];
  logic        log_last [NCH][LOGN];
  logic        log_wr   [NCH][LOGN];
  int          log_n    [NCH] = '{0, 0, 0};

  function automatic int ch_idx(input logic [2:0] c);
    if (c == 3'b001) return 0;
    if (c == 3'b010) return 1;
    if (c == 3'b100) return 2;
    return -1;
  endfunction

  always @(negedge CLK) begin : mon
    int   ci;
    logic rej, full, exp_rdy, any_q, ev;
    logic [15:0] ea;
    logic mv [NCH];
    ci      = ch_idx(in_chan);
    rej     = in_valid && !RST && !flush && (ci < 0 || in_opcode > 5'd3 || in_num_words == 16'd0);
    full    = (ci >= 0) ? (mcnt[ci] >= D) : 1'b0;
    exp_rdy = !RST && !flush && ((ci >= 0 && !full) || rej);
    any_q   = 1'b0;
    for (int c = 0; c < NCH; c++) any_q = any_q | (mcnt[c] > 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("in_err", 32'(in_err), 32'(exp_err));
    chk("busy", 32'(busy), 32'(any_q));
    for (int c = 0; c < NCH; c++) begin
      ev    = (mcnt[c] > 0) && (mage[c] >= 2);
      mv[c] = ev;
      chk("req_valid", 32'(req_valid[c]), 32'(ev));
      chk("occupancy", 32'(occupancy[c*CW +: CW]), 32'(mcnt[c]));
      if (ev) begin
        ea = 16'(32'(mq[c][0].base) + mk[c] * int'(mq[c][0].stride));
        chk("req_addr", 32'(req_addr[c*AW +: AW]), 32'(ea));
        chk("req_last", 32'(req_last[c]), 32'(mk[c] == mq[c][0].nw - 1));
        chk("req_write", 32'(req_write[c]), 32'(mq[c][0].wr));
        chk("req_width", 32'(req_width[c*3 +: 3]), 32'(mq[c][0].w));
      end
    end
    if (RST || flush) begin
      for (int c = 0; c < NCH; c++) begin
        mcnt[c] = 0; mk[c] = 0; mage[c] = 0;
      end
      exp_err = 1'b0;
    end else begin
      exp_err = rej;
      for (int c = 0; c < NCH; c++) begin
        if (mv[c] && req_ready[c]) begin
          if (log_n[c] < LOGN) begin
            log_addr[c][log_n[c]] = req_addr[c*AW +: AW];
            log_last[c][log_n[c]] = req_last[c];
            log_wr[c][log_n[c]]   = req_write[c];
          end
          log_n[c]++;
          mk[c]++;
          if (mk[c] == mq[c][0].nw) begin
            for (int j = 0; j < D + 1; j++) mq[c][j] = mq[c][j+1];
            mcnt[c]--;
            mk[c]   = 0;
            mage[c] = 0;
          end
        end else if (mcnt[c] > 0 && mage[c] < 2) begin
          mage[c]++;
        end
      end
      if (in_valid && exp_rdy && !rej) begin
        if (mcnt[ci] == 0) mage[ci] = 0;
        mq[ci][mcnt[ci]].base   = in_base;
        mq[ci][mcnt[ci]].stride = in_stride;
        mq[ci][mcnt[ci]].nw     = int'(in_num_words);
        mq[ci][mcnt[ci]].wr     = (in_opcode == 5'd1) || (in_opcode == 5'd3);
        mq[ci][mcnt[ci]].w      = in_mem_width;
        mcnt[ci]++;
      end
    end
  end

  task automatic present(input logic [2:0] ch, input logic [4:0] op, input logic [2:0] w,
                         input logic [15:0] nw, input logic [15:0] base, input logic [15:0] stride);
    in_valid = 1'b1; in_chan = ch; in_opcode = op; in_mem_width = w;
    in_num_words = nw; in_base = base; in_stride = stride;
  endtask

  task automatic push(input logic [2:0] ch, input logic [4:0] op, input logic [2:0] w,
                      input logic [15:0] nw, input logic [15:0] base, input logic [15:0] stride);
    present(ch, op, w, nw, base, stride);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (busy !== 1'b0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(n < 300), 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic wait_valid(input int c);
    int n;
    n = 0;
    @(negedge CLK);
    while (req_valid[c] !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_valid", 32'(n < 50), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, n, ovl;
    logic [2:0]  rj_ch [3];
    logic [4:0]  rj_op [3];
    logic [15:0] rj_nw [3];
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_chan = 3'b001; in_opcode = 5'd0;
    in_mem_width = 3'd0; in_num_words = 16'd1; in_base = 16'd0; in_stride = 16'd0;
    req_ready = '0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_addr", 32'(req_addr[31:0]), 32'd0);
    chk("rst_err", 32'(in_err), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // 1: basic strided load, latency and sequence
    req_ready = 3'b001;
    b = log_n[0];
    push(SP_IBUF, OP_LD_MEM, 3'd2, 16'd4, 16'h0100, 16'd2);
    @(negedge CLK); chk("t1_lat0", 32'(req_valid[0]), 32'd0);
    @(negedge CLK); chk("t1_lat1", 32'(req_valid[0]), 32'd0);
    @(negedge CLK); chk("t1_lat2", 32'(req_valid[0]), 32'd1);
    @(posedge CLK); #1;
    wait_idle("t1_idle");
    chk("t1_n", 32'(log_n[0] - b), 32'd4);
    chk("t1_a0", 32'(log_addr[0][b]), 32'h0100);
    chk("t1_a1", 32'(log_addr[0][b+1]), 32'h0102);
    chk("t1_a2", 32'(log_addr[0][b+2]), 32'h0104);
    chk("t1_a3", 32'(log_addr[0][b+3]), 32'h0106);
    chk("t1_last", 32'({log_last[0][b], log_last[0][b+1], log_last[0][b+2], log_last[0][b+3]}), 32'b0001);
    chk("t1_wr", 32'(log_wr[0][b]), 32'd0);
    chk("t1_occ", 32'(occupancy[0 +: CW]), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: address wrap with backpressure
    req_ready = 3'b000;
    b = log_n[1];
    push(SP_WBUF, OP_ST_MEM, 3'd1, 16'd3, 16'hFFFE, 16'd1);
    wait_valid(1);
    foreach (rj_ch[i]) rj_ch[i] = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      req_ready[1] = (i == 1 || i == 4 || i == 5);
    end
    @(posedge CLK); #1;
    req_ready[1] = 1'b0;
    wait_idle("t2_idle");
    chk("t2_n", 32'(log_n[1] - b), 32'd3);
    chk("t2_a0", 32'(log_addr[1][b]), 32'hFFFE);
    chk("t2_a1", 32'(log_addr[1][b+1]), 32'hFFFF);
    chk("t2_a2", 32'(log_addr[1][b+2]), 32'h0000);
    chk("t2_last", 32'(log_last[1][b+2]), 32'd1);
    chk("t2_wr", 32'(log_wr[1][b]), 32'd1);

    // 3: fill channel 0, then release one slot
    req_ready = 3'b000;
    b = log_n[0];
    for (int i = 0; i < D; i++) push(SP_IBUF, OP_RD_BUF, 3'd3, 16'd2, 16'(16'h0200 + i * 16), 16'd1);
    present(SP_IBUF, OP_RD_BUF, 3'd3, 16'd2, 16'h0300, 16'd1);
    @(negedge CLK);
    chk("t3_full_rdy", 32'(in_ready), 32'd0);
    chk("t3_full_occ", 32'(occupancy[0 +: CW]), 32'd10);
    chk("t3_live", 32'(req_valid[0]), 32'd1);
    @(posedge CLK); #1;
    req_ready[0] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge CLK);
      n++;
      if (in_ready === 1'b1) break;
    end
    chk("t3_release", 32'(n), 32'd3);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_idle("t3_idle");
    chk("t3_n", 32'(log_n[0] - b), 32'd22);
    chk("t3_alast", 32'(log_addr[0][b+21]), 32'h0301);

    // 4: rejects
    rj_ch[0] = 3'b011; rj_op[0] = 5'd0; rj_nw[0] = 16'd1;
    rj_ch[1] = 3'b001; rj_op[1] = 5'd4; rj_nw[1] = 16'd1;
    rj_ch[2] = 3'b001; rj_op[2] = 5'd0; rj_nw[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      present(rj_ch[i], rj_op[i], 3'd0, rj_nw[i], 16'h0500, 16'd1);
      @(negedge CLK);
      chk("t4_rdy", 32'(in_ready), 32'd1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK);
      chk("t4_err", 32'(in_err), 32'd1);
      chk("t4_occ", 32'(occupancy), 32'd0);
      @(posedge CLK); #1;
    end

    // 5: all three channels overlapped
    req_ready = 3'b111;
    b = log_n[1];
    n = log_n[2];
    push(SP_IBUF, OP_LD_MEM, 3'd0, 16'd3, 16'h1000, 16'h0010);
    push(SP_WBUF, OP_RD_BUF, 3'd5, 16'd3, 16'h2000, 16'd0);
    push(SP_OBUF, OP_WR_BUF, 3'd7, 16'd3, 16'h3000, 16'h0100);
    ovl = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (req_valid === 3'b111) ovl++;
      if (busy === 1'b0) break;
    end
    chk("t5_overlap", 32'(ovl), 32'd1);
    chk("t5_b_a2", 32'(log_addr[1][b+2]), 32'h2000);
    chk("t5_c_a2", 32'(log_addr[2][n+2]), 32'h3200);
    chk("t5_c_wr", 32'(log_wr[2][n]), 32'd1);
    @(posedge CLK); #1;
    wait_idle("t5_idle");

    // 6: flush mid-descriptor with a push in the same cycle
    req_ready = 3'b000;
    push(SP_IBUF, OP_ST_MEM, 3'd1, 16'd5, 16'h0300, 16'd4);
    wait_valid(0);
    @(posedge CLK); #1; req_ready[0] = 1'b1;
    @(posedge CLK); #1; req_ready[0] = 1'b0;
    flush = 1'b1;
    b = log_n[1];
    present(SP_WBUF, OP_LD_MEM, 3'd0, 16'd1, 16'h0050, 16'd0);
    @(posedge CLK); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    chk("t6_valid", 32'(req_valid), 32'd0);
    chk("t6_occ", 32'(occupancy), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err0", 32'(in_err), 32'd0);
    @(negedge CLK);
    chk("t6_err1", 32'(in_err), 32'd0);
    @(posedge CLK); #1;
    req_ready = 3'b001;
    n = log_n[0];
    push(SP_IBUF, OP_LD_MEM, 3'd2, 16'd2, 16'h0400, 16'd8);
    wait_idle("t6_idle");
    chk("t6_n", 32'(log_n[0] - n), 32'd2);
    chk("t6_a0", 32'(log_addr[0][n]), 32'h0400);
    chk("t6_a1", 32'(log_addr[0][n+1]), 32'h0408);
    chk("t6_drop", 32'(log_n[1] - b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/buf_table_issue.md
Name: buf_table_issue

Overview:
- Parametrised multi-channel buffer table with per-channel address issue engines.
- The instruction decoder pushes buffer-access descriptors tagged with a one-hot scratchpad channel. Default channels are IBUF, WBUF and OBUF.
- Each channel queues descriptors in a DEPTH-entry FIFO. It expands each descriptor into num_words word requests (base + k*stride) on a valid/ready port toward its scratchpad/memory.
- Successor to the single fixed buffer table: configurable channel count, depth, address width, and strided address generation.

Parameters:
NUM_CH, 3, number of scratchpad channels (one-hot tag width)
DEPTH, 10, descriptor FIFO entries per channel (any value >= 2, not required pow2)
ADDR_W, 16, request address width
OP_W, 5, opcode width
IMM_W, 16, num_words / stride width

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all FIFOs and engines
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid & in_ready
in_chan  in  NUM_CH  one-hot target channel
in_opcode  in  OP_W  LD_MEM / ST_MEM / RD_BUF / WR_BUF
in_mem_width  in  3  element width code, passed through
in_num_words  in  IMM_W  word count, must be nonzero
in_base  in  ADDR_W  start address
in_stride  in  IMM_W  address increment, zero-extended to ADDR_W
in_err  out  1  one-cycle pulse: descriptor rejected
req_valid  out  NUM_CH  per-channel request valid
req_ready  in  NUM_CH  per-channel request ready
req_addr  out  NUM_CH*ADDR_W  per-channel address, channel c at [c*ADDR_W +: ADDR_W]
req_width  out  NUM_CH*3  per-channel mem_width
req_write  out  NUM_CH  1 for ST_MEM/WR_BUF, 0 for LD_MEM/RD_BUF
req_last  out  NUM_CH  final word of descriptor
occupancy  out  NUM_CH*$clog2(DEPTH+1)  per-channel FIFO count
busy  out  1  OR of any FIFO nonempty or any engine not IDLE

Behaviour:
- Reset: RST=1 at an edge clears all FIFOs and engines. Engines go to IDLE. req_valid, req_last, in_err and busy are 0. occupancy is 0. req_addr, req_width and req_write are 0.
- Reset mid-transfer abandons the transfer with no further requests.
- in_ready is combinational: !RST & !flush & (in_chan one-hot) & (target FIFO not full).
- A full FIFO is never ready, even if it pops in the same cycle (no bypass).
- Reject rule: in_valid & !RST & !flush with (in_chan not one-hot) OR (opcode not in the four buffer ops) OR (num_words==0).
  - in_ready is forced 1 so the decoder does not stall.
  - Nothing is stored.
  - in_err pulses the following cycle.
- Push accepted at edge t: occupancy increments at t+1.
- Engine FSM per channel: IDLE -> LOAD -> ISSUE -> IDLE.
  - IDLE: if FIFO nonempty, go to LOAD.
  - LOAD: latch the head into working registers, k=0, addr=base.
  - ISSUE: req_valid=1, req_addr=addr, req_last=(k==num_words-1).
  - On a req_valid & req_ready handshake: addr += stride, truncated mod 2^ADDR_W, wrap permitted; k += 1.
  - On the handshake with req_last: pop the FIFO head and go to IDLE.
- Minimum latency: push at edge t -> IDLE sees nonempty in cycle t+1 -> LOAD in t+2 -> req_valid in t+3.
- A one-cycle bubble (IDLE) occurs between descriptors.
- While req_valid=1, req_addr, req_width, req_write and req_last hold stable until the handshake. req_valid never drops without a handshake, except on flush/RST.
- Channels are fully independent; no cross-channel ordering.
- Simultaneous push and pop on the same channel: occupancy is unchanged, and the pointers both advance with wrap at DEPTH.
- flush=1 at an edge: same effect as RST on FIFOs, engines and req_valid. A push in the flush cycle is dropped, and no in_err is raised. A flush mid-descriptor discards that descriptor's remaining words.
- num_words=1 produces one request with req_last=1.
- stride=0 repeats the same address num_words times.

Decomposition:
- Shared package:
  - opcode enum (OP_W)
  - scratchpad_t as a 3-bit one-hot enum (IBUF=001, WBUF=010, OBUF=100)
  - buf_desc_t packed struct (opcode, mem_width, num_words, base, stride)
  - BUFF_TABLE_DEPTH default
  - IMM_W/OP_W constants
  - engine state enum
- Sub-module buf_chan_engine: one FIFO plus issue FSM per channel, instantiated NUM_CH times by generate.
- The top level holds only acceptance/reject logic and port packing.

Test Plan:
1. Reset then push {chan=001, LD_MEM, num_words=4, base=0x0100, stride=2} with req_ready[0]=1 -> req_valid[0] from 3 cycles after the push. Addresses 0x0100, 0x0102, 0x0104, 0x0106, with req_last only on 0x0106. req_write=0. occupancy[0] back to 0, busy=0 afterwards.
2. Wrap and backpressure: push {chan=010, ST_MEM, num_words=3, base=0xFFFE, stride=1}; toggle req_ready[1] 0,1,0,0,1,1 -> addresses 0xFFFE, 0xFFFF, 0x0000. Each held stable during stall cycles. req_write=1.
3. Full: push 10 descriptors to channel 0 with req_ready[0]=0 -> in_ready=0 on the 11th. First request is live; raising req_ready frees one slot after the last word of descriptor 1, and an 11th push is then accepted.
4. Rejects: in_chan=011; opcode=COMPUTE; num_words=0 -> each accepted with in_err pulsed the next cycle, occupancy unchanged.
5. Concurrency: descriptors to all three channels in consecutive cycles, with req_ready all 1 -> all three engines issue overlapped, and per-channel address sequences are correct.
6. Flush mid-transfer (word 2 of 5) plus a push in the same cycle -> next cycle req_valid=0, occupancy=0, busy=0, no in_err. A subsequent push issues normally.
